// File: rtl/fix_timestamp_counter.sv
// BCD calendar timestamp counter (fraction, SS, MM, HH, DD, MM, YYYY) with single-cycle carry
// resolution, leap-year aware date rollover and validated loading.
module fix_timestamp_counter #(
    parameter  int FRAC_DIGITS = 3,
    localparam int NDIG        = 14 + FRAC_DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_ts,
    output logic [4*NDIG-1:0] ts,
    output logic              ts_valid,
    output logic              load_err,
    output logic              sec_strobe,
    output logic              day_strobe
);
    localparam int SEC = FRAC_DIGITS;
    localparam int MIN = SEC + 2;
    localparam int HR  = SEC + 4;
    localparam int DAY = SEC + 6;
    localparam int MON = SEC + 8;
    localparam int YR  = SEC + 10;

    typedef logic [4*NDIG-1:0] ts_t;

    function automatic logic [7:0] bcd2_inc(input logic [7:0] b);
        if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'd0};
        else                return {b[7:4], b[3:0] + 4'd1};
    endfunction

    // 9999 wraps to 0000 naturally because the final carry is dropped.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two-digit BCD number divisible by 4: even tens need units 0/4/8, odd tens need 2/6.
    function automatic logic div4(input logic [3:0] tens, input logic [3:0] units);
        if (tens[0]) return (units == 4'd2) || (units == 4'd6);
        else         return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    endfunction

    function automatic logic is_leap(input logic [15:0] y);
        logic century;
        century = (y[7:0] == 8'h00);
        return div4(y[7:4], y[3:0]) && (!century || div4(y[15:12], y[11:8]));
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] mon, input logic [15:0] y);
        case (mon)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    // Byte-wise compares of packed BCD are numeric once every digit is known to be <= 9.
    function automatic logic ts_legal(input ts_t v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIG; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        if (v[4*SEC +: 8] > 8'h59) ok = 1'b0;
        if (v[4*MIN +: 8] > 8'h59) ok = 1'b0;
        if (v[4*HR +: 8] > 8'h23) ok = 1'b0;
        if (v[4*MON +: 8] == 8'h00 || v[4*MON +: 8] > 8'h12) ok = 1'b0;
        if (v[4*DAY +: 8] == 8'h00 ||
            v[4*DAY +: 8] > days_in_month(v[4*MON +: 8], v[4*YR +: 16])) ok = 1'b0;
        return ok;
    endfunction

    function automatic ts_t reset_ts();
        ts_t v;
        v = '0;
        v[4*DAY +: 8] = 8'h01;
        v[4*MON +: 8] = 8'h01;
        v[4*YR +: 16] = 16'h1970;
        return v;
    endfunction

    ts_t  ts_next;
    logic sec_adv;
    logic day_adv;
    logic load_ok;
    logic carry;

    assign load_ok = ts_legal(load_ts);

    // Whole carry chain is combinational so one tick settles in a single cycle.
    always_comb begin
        ts_next = ts;
        carry   = tick;
        for (int i = 0; i < FRAC_DIGITS; i++) begin
            if (carry) begin
                if (ts[4*i +: 4] == 4'd9) ts_next[4*i +: 4] = 4'd0;
                else begin
                    ts_next[4*i +: 4] = ts[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        sec_adv = carry;
        if (carry) begin
            if (ts[4*SEC +: 8] == 8'h59) ts_next[4*SEC +: 8] = 8'h00;
            else begin
                ts_next[4*SEC +: 8] = bcd2_inc(ts[4*SEC +: 8]);
                carry = 1'b0;
            end
        end
        if (carry) begin
            if (ts[4*MIN +: 8] == 8'h59) ts_next[4*MIN +: 8] = 8'h00;
            else begin
                ts_next[4*MIN +: 8] = bcd2_inc(ts[4*MIN +: 8]);
                carry = 1'b0;
            end
        end
        if (carry) begin
            if (ts[4*HR +: 8] == 8'h23) ts_next[4*HR +: 8] = 8'h00;
            else begin
                ts_next[4*HR +: 8] = bcd2_inc(ts[4*HR +: 8]);
                carry = 1'b0;
            end
        end
        day_adv = carry;
        if (carry) begin
            if (ts[4*DAY +: 8] == days_in_month(ts[4*MON +: 8], ts[4*YR +: 16]))
                ts_next[4*DAY +: 8] = 8'h01;
            else begin
                ts_next[4*DAY +: 8] = bcd2_inc(ts[4*DAY +: 8]);
                carry = 1'b0;
            end
        end
        if (carry) begin
            if (ts[4*MON +: 8] == 8'h12) ts_next[4*MON +: 8] = 8'h01;
            else begin
                ts_next[4*MON +: 8] = bcd2_inc(ts[4*MON +: 8]);
                carry = 1'b0;
            end
        end
        if (carry) ts_next[4*YR +: 16] = bcd4_inc(ts[4*YR +: 16]);
    end

    // A legal load overrides any tick in the same cycle; a rejected load lets the tick through.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts         <= reset_ts();
            ts_valid   <= 1'b0;
            load_err   <= 1'b0;
            sec_strobe <= 1'b0;
            day_strobe <= 1'b0;
        end else if (load && load_ok) begin
            ts         <= load_ts;
            ts_valid   <= 1'b1;
            load_err   <= 1'b0;
            sec_strobe <= 1'b0;
            day_strobe <= 1'b0;
        end else begin
            ts         <= ts_next;
            load_err   <= load;
            sec_strobe <= sec_adv;
            day_strobe <= day_adv;
        end
    end
endmodule

// File: tb/tb_fix_timestamp_counter.sv
// Randomized and directed bench for fix_timestamp_counter against an integer calendar model,
// with extra instances for 6 and 0 fractional digits.
module tb_fix_timestamp_counter;
    localparam int W3 = 4 * 17;
    localparam int W6 = 4 * 20;
    localparam int W0 = 4 * 14;
    typedef logic [91:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          tick3, load3, val3, err3, sec3, day3;
    logic [W3-1:0] lts3, ts3;
    logic          tick6, load6, val6, err6, sec6, day6;
    logic [W6-1:0] lts6, ts6;
    logic          tick0, load0, val0, err0, sec0, day0;
    logic [W0-1:0] lts0, ts0;

    fix_timestamp_counter #(.FRAC_DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .tick(tick3), .load(load3), .load_ts(lts3), .ts(ts3),
        .ts_valid(val3), .load_err(err3), .sec_strobe(sec3), .day_strobe(day3));
    fix_timestamp_counter #(.FRAC_DIGITS(6)) dut6 (
        .clk(clk), .rst(rst), .tick(tick6), .load(load6), .load_ts(lts6), .ts(ts6),
        .ts_valid(val6), .load_err(err6), .sec_strobe(sec6), .day_strobe(day6));
    fix_timestamp_counter #(.FRAC_DIGITS(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick0), .load(load0), .load_ts(lts0), .ts(ts0),
        .ts_valid(val0), .load_err(err0), .sec_strobe(sec0), .day_strobe(day0));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int p10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int mdays(input int y, input int mo);
        bit leap;
        leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
        case (mo)
            4, 6, 9, 11: return 30;
            2:           return leap ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic vec_t to_bcd(input int f, input int y, input int mo, input int d,
                                    input int h, input int mi, input int s, input int fr);
        vec_t v;
        int   x;
        v = '0;
        x = fr;
        for (int i = 0; i < f; i++) begin
            v[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        v[4*f +: 8]      = {4'(s / 10), 4'(s % 10)};
        v[4*(f+2) +: 8]  = {4'(mi / 10), 4'(mi % 10)};
        v[4*(f+4) +: 8]  = {4'(h / 10), 4'(h % 10)};
        v[4*(f+6) +: 8]  = {4'(d / 10), 4'(d % 10)};
        v[4*(f+8) +: 8]  = {4'(mo / 10), 4'(mo % 10)};
        v[4*(f+10) +: 16] = {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
        return v;
    endfunction

    function automatic int fld(input vec_t v, input int lo, input int n);
        int r;
        r = 0;
        for (int i = n - 1; i >= 0; i--) r = r * 10 + int'(v[4*(lo+i) +: 4]);
        return r;
    endfunction

    function automatic bit model_legal(input vec_t v, input int f);
        int s, mi, h, d, mo, y;
        for (int i = 0; i < f + 14; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        s  = fld(v, f, 2);
        mi = fld(v, f + 2, 2);
        h  = fld(v, f + 4, 2);
        d  = fld(v, f + 6, 2);
        mo = fld(v, f + 8, 2);
        y  = fld(v, f + 10, 4);
        return (s < 60) && (mi < 60) && (h < 24) && (mo >= 1) && (mo <= 12) &&
               (d >= 1) && (d <= mdays(y, mo));
    endfunction

    int m_y, m_mo, m_d, m_h, m_mi, m_s, m_fr;
    bit m_valid;

    function automatic vec_t mk(input int y, input int mo, input int d, input int h,
                                input int mi, input int s, input int fr);
        return to_bcd(3, y, mo, d, h, mi, s, fr);
    endfunction

    task automatic model_advance(output bit s_adv, output bit d_adv);
        s_adv = 1'b0;
        d_adv = 1'b0;
        m_fr++;
        if (m_fr == 1000) begin
            m_fr = 0; s_adv = 1'b1; m_s++;
            if (m_s == 60) begin
                m_s = 0; m_mi++;
                if (m_mi == 60) begin
                    m_mi = 0; m_h++;
                    if (m_h == 24) begin
                        m_h = 0; d_adv = 1'b1; m_d++;
                        if (m_d > mdays(m_y, m_mo)) begin
                            m_d = 1; m_mo++;
                            if (m_mo == 13) begin
                                m_mo = 1;
                                m_y = (m_y + 1) % 10000;
                            end
                        end
                    end
                end
            end
        end
    endtask

    // One clock of the 3-digit instance: drive, step the model, compare every output.
    task automatic cyc(input bit r, input bit t, input bit l, input vec_t v);
        bit e_sec, e_day, e_err;
        rst = r; tick3 = t; load3 = l; lts3 = v[W3-1:0];
        @(posedge clk);
        #1;
        e_sec = 1'b0; e_day = 1'b0; e_err = 1'b0;
        if (!r) begin
            m_y = 1970; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_fr = 0;
            m_valid = 1'b0;
        end else if (l && model_legal(v, 3)) begin
            m_fr = fld(v, 0, 3);  m_s = fld(v, 3, 2);  m_mi = fld(v, 5, 2);
            m_h  = fld(v, 7, 2);  m_d = fld(v, 9, 2);  m_mo = fld(v, 11, 2);
            m_y  = fld(v, 13, 4);
            m_valid = 1'b1;
        end else begin
            e_err = l;
            if (t) model_advance(e_sec, e_day);
        end
        check_val("ts", ts3, mk(m_y, m_mo, m_d, m_h, m_mi, m_s, m_fr));
        check_val("ts_valid", val3, m_valid);
        check_val("load_err", err3, e_err);
        check_val("sec_strobe", sec3, e_sec);
        check_val("day_strobe", day3, e_day);
        rst = 1'b1; tick3 = 1'b0; load3 = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   y, mo, d, h, mi, s, fr, ns, nd;
        rst = 1'b0;
        tick3 = 1'b0; load3 = 1'b0; lts3 = '0;
        tick6 = 1'b0; load6 = 1'b0; lts6 = '0;
        tick0 = 1'b0; load0 = 1'b0; lts0 = '0;

        cyc(1'b0, 1'b0, 1'b0, '0);
        check_val("reset_ts", ts3, mk(1970, 1, 1, 0, 0, 0, 0));
        cyc(1'b0, 1'b1, 1'b1, mk(2023, 5, 5, 5, 5, 5, 5));
        cyc(1'b1, 1'b1, 1'b0, '0);
        check_val("tick_before_load", ts3, mk(1970, 1, 1, 0, 0, 0, 1));

        cyc(1'b1, 1'b0, 1'b1, mk(2023, 12, 31, 23, 59, 59, 999));
        cyc(1'b1, 1'b1, 1'b0, '0);
        check_val("new_year", ts3, mk(2024, 1, 1, 0, 0, 0, 0));
        check_val("new_year_sec", sec3, 1);
        check_val("new_year_day", day3, 1);

        cyc(1'b1, 1'b0, 1'b1, mk(2024, 2, 28, 23, 59, 59, 999));
        cyc(1'b1, 1'b1, 1'b0, '0);
        check_val("leap_2024", ts3, mk(2024, 2, 29, 0, 0, 0, 0));
        cyc(1'b1, 1'b0, 1'b1, mk(2100, 2, 28, 23, 59, 59, 999));
        cyc(1'b1, 1'b1, 1'b0, '0);
        check_val("noleap_2100", ts3, mk(2100, 3, 1, 0, 0, 0, 0));
        cyc(1'b1, 1'b0, 1'b1, mk(2000, 2, 28, 23, 59, 59, 999));
        cyc(1'b1, 1'b1, 1'b0, '0);
        check_val("leap_2000", ts3, mk(2000, 2, 29, 0, 0, 0, 0));
        cyc(1'b1, 1'b0, 1'b1, mk(9999, 12, 31, 23, 59, 59, 999));
        cyc(1'b1, 1'b1, 1'b0, '0);
        check_val("year_wrap", ts3, mk(0, 1, 1, 0, 0, 0, 0));

        cyc(1'b1, 1'b0, 1'b1, mk(2023, 2, 29, 12, 0, 0, 0));
        check_val("bad_feb29_err", err3, 1);
        check_val("bad_feb29_ts", ts3, mk(0, 1, 1, 0, 0, 0, 0));
        cyc(1'b1, 1'b0, 1'b0, '0);
        check_val("err_one_cycle", err3, 0);
        cyc(1'b1, 1'b0, 1'b1, mk(2023, 6, 15, 24, 0, 0, 0));
        check_val("bad_hour_err", err3, 1);
        v = mk(2023, 6, 15, 10, 0, 0, 0);
        v[4*5 +: 4] = 4'hA;
        cyc(1'b1, 1'b1, 1'b1, v);
        check_val("bad_digit_tick", ts3, mk(0, 1, 1, 0, 0, 0, 1));

        cyc(1'b1, 1'b1, 1'b1, mk(2023, 6, 15, 10, 20, 30, 400));
        check_val("collision", ts3, mk(2023, 6, 15, 10, 20, 30, 400));

        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, mk(2023, 6, 15, 10, 20, 30, 400));
        check_val("midrun_reset", ts3, mk(1970, 1, 1, 0, 0, 0, 0));

        repeat (3000) begin
            case ($urandom_range(0, 3))
                0:       y = 1900;
                1:       y = 2000;
                2:       y = 2100;
                default: y = $urandom_range(0, 9999);
            endcase
            mo = $urandom_range(0, 13);
            d  = $urandom_range(0, 1) ? mdays(y, mo) : $urandom_range(0, 31);
            if ($urandom_range(0, 1)) begin
                h = 23; mi = 59; s = 59; fr = 999 - $urandom_range(0, 3);
            end else begin
                h = $urandom_range(0, 24); mi = $urandom_range(0, 59);
                s = $urandom_range(0, 59); fr = $urandom_range(0, 999);
            end
            v = mk(y, mo, d, h, mi, s, fr);
            if ($urandom_range(0, 9) == 0) v[4*$urandom_range(0, 16) +: 4] = 4'($urandom_range(10, 15));
            cyc(($urandom_range(0, 499) != 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0, v);
        end

        v = to_bcd(6, 1970, 1, 1, 0, 0, 0, 990000);
        lts6 = v[W6-1:0]; load6 = 1'b1;
        @(posedge clk);
        #1;
        load6 = 1'b0;
        check_val("f6_load", ts6, v);
        check_val("f6_valid", val6, 1);
        check_val("f6_err", err6, 0);
        tick6 = 1'b1;
        ns = 0;
        repeat (9999) begin
            @(posedge clk);
            #1;
            if (sec6) ns++;
        end
        check_val("f6_no_sec", ns, 0);
        check_val("f6_all_nines", ts6, to_bcd(6, 1970, 1, 1, 0, 0, 0, 999999));
        @(posedge clk);
        #1;
        tick6 = 1'b0;
        check_val("f6_sec_roll", ts6, to_bcd(6, 1970, 1, 1, 0, 0, 1, 0));
        check_val("f6_sec_strobe", sec6, 1);
        check_val("f6_day_strobe", day6, 0);

        v = to_bcd(0, 1970, 1, 1, 12, 0, 0, 0);
        lts0 = v[W0-1:0]; load0 = 1'b1;
        @(posedge clk);
        #1;
        load0 = 1'b0;
        check_val("f0_load", ts0, v);
        check_val("f0_valid", val0, 1);
        check_val("f0_err", err0, 0);
        tick0 = 1'b1;
        ns = 0; nd = 0;
        repeat (43200) begin
            @(posedge clk);
            #1;
            if (sec0) ns++;
            if (day0) nd++;
        end
        tick0 = 1'b0;
        check_val("f0_sec_count", ns, 43200);
        check_val("f0_day_count", nd, 1);
        check_val("f0_day_last", day0, 1);
        check_val("f0_next_day", ts0, to_bcd(0, 1970, 1, 2, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fix_timestamp_counter.md
FIX_TIMESTAMP_COUNTER -- requirements
Module: fix_timestamp_counter

Interface
REQ-001 Parameter FRAC_DIGITS, default 3; number of fractional-second BCD digits; legal values 0, 3, 6, 9.
REQ-002 Parameter NDIG, default 14+FRAC_DIGITS; total digit count, derived, not overridable.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port tick  input  1  one-cycle pulse = one least-significant fractional unit (1 s when FRAC_DIGITS=0).
REQ-006 Port load  input  1  one-cycle request to set the time from load_ts.
REQ-007 Port load_ts  input  4*NDIG  BCD digits; digit 0 = least-significant fraction; order fraction, SS, MM, HH, DD, MM, YYYY.
REQ-008 Port ts  output  4*NDIG  current registered timestamp, same digit order as load_ts.
REQ-009 Port ts_valid  output  1  high once a legal load has been accepted.
REQ-010 Port load_err  output  1  one-cycle pulse: load rejected.
REQ-011 Port sec_strobe  output  1  one-cycle pulse: seconds field advanced.
REQ-012 Port day_strobe  output  1  one-cycle pulse: date field advanced.

Function
REQ-013 Full carry chain resolves in one cycle: tick sampled at edge N, ts shows incremented value after edge N; no multi-cycle ripple.
REQ-014 Digit ranges: fraction digits 0-9; seconds 00-59; minutes 00-59; hours 00-23; day 01-days_in_month; month 01-12; year 0000-9999.
REQ-015 days_in_month: 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11; 28/29 for 02 per leap.
REQ-016 leap = year divisible by 4 AND (year not divisible by 100 OR divisible by 400), computed directly on BCD digits, no binary conversion, no lookup table of years.
REQ-017 Rollovers: 23:59:59 -> 00:00:00 with day+1; last day of month -> day 01, month+1; month 12 -> 01, year+1; year 9999 -> 0000.
REQ-018 sec_strobe asserts in the same cycle ts shows the new second; day_strobe in the same cycle ts shows the new date; both low otherwise.
REQ-019 Load validation: every digit <=9 and every field within REQ-014/REQ-015 ranges, leap evaluated on load_ts year.
REQ-020 Legal load: ts <= load_ts after the sampling edge, ts_valid <= 1, no strobes that cycle.
REQ-021 Illegal load: ts unchanged, tick that cycle still applied, load_err=1 for one cycle, ts_valid unchanged.
REQ-022 load and tick same cycle: legal load wins, tick discarded; illegal load: tick applied.
REQ-023 tick while ts_valid=0: counter still advances from reset value.
REQ-024 ts never holds an out-of-range value except via reset.

Reset
REQ-025 rst=0 at a rising edge: ts <= 19700101-00:00:00 with all fraction digits 0; ts_valid, load_err, sec_strobe, day_strobe <= 0.
REQ-026 rst has priority over load and tick; reset mid-carry leaves no residual carry state.
REQ-027 No initial blocks or power-up values relied on; behaviour defined only after first reset.

Verification
REQ-028 FRAC_DIGITS=3: load 20231231-23:59:59.999, one tick -> 20240101-00:00:00.000, sec_strobe=1 and day_strobe=1 same cycle.
REQ-029 Leap: load 20240228-23:59:59.999 + tick -> 20240229; load 21000228-23:59:59.999 + tick -> 21000301; load 20000228-23:59:59.999 + tick -> 20000229.
REQ-030 Illegal: load 20230229-12:00:00.000 -> load_err=1 one cycle, ts unchanged; load with hour 24 or digit 0xA -> same.
REQ-031 Collision: load 20230615-10:20:30.400 with tick same cycle -> ts=20230615-10:20:30.400 exactly.
REQ-032 FRAC_DIGITS=6 and 0: 999999 ticks from 00:00:00.000000 -> 00:00:00.999999, no sec_strobe; one more -> 00:00:01.000000 with sec_strobe; FRAC_DIGITS=0, 86400 ticks from 19700101-00:00:00 -> 19700102-00:00:00.
REQ-033 Reset mid-run with load and tick asserted -> ts=19700101-00:00:00.000, all flags 0 next cycle.
